// File: rtl/dilithium_pkg.sv
// ============================================================================
// Module      : dilithium_pkg
// Description : Shared t1 packing constants and FSM state encoding used by
//               the t1 packer and unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dilithium_pkg;

    localparam int N       = 256;
    localparam int TBITS   = 10;
    localparam int COEFF_W = 32;
    localparam int NBYTES  = N * TBITS / 8;

    // Bit buffer geometry: at most 9 leftover bits plus one inserted byte.
    localparam int BUF_W   = 18;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dilithium_pkg

`default_nettype wire

// File: rtl/t1_bitbuf.sv
// ============================================================================
// Module      : t1_bitbuf
// Description : 18-bit LSB-first bit accumulator; pushes bytes in, pops
//               10-bit coefficients out. Pop is applied before push.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t1_bitbuf
    import dilithium_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_push,
    input  logic [7:0]           i_byte,
    input  logic                 i_pop,
    output logic [TBITS-1:0]     o_bits,
    output logic [CNT_W-1:0]     o_cnt
);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    logic [BUF_W-1:0] w_base;
    logic [CNT_W-1:0] w_pos;
    logic [BUF_W-1:0] w_ins;
    logic [BUF_W-1:0] w_next_buf;
    logic [CNT_W-1:0] w_next_cnt;

    // The insertion point follows the post-shift bit count so a simultaneous
    // push lands directly above the bits that survive the pop.
    always_comb begin
        w_base     = i_pop ? (r_buf >> TBITS) : r_buf;
        w_pos      = i_pop ? (r_cnt - CNT_W'(TBITS)) : r_cnt;
        w_ins      = BUF_W'(i_byte) << w_pos;
        w_next_buf = i_push ? (w_base | w_ins) : w_base;
        w_next_cnt = w_pos + (i_push ? CNT_W'(8) : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_push || i_pop) begin
            r_buf <= w_next_buf;
            r_cnt <= w_next_cnt;
        end
    end

    assign o_bits = r_buf[TBITS-1:0];
    assign o_cnt  = r_cnt;

endmodule : t1_bitbuf

`default_nettype wire

// File: rtl/polyt1_unpack_stream.sv
// ============================================================================
// Module      : polyt1_unpack_stream
// Description : Streams 320 packed t1 bytes in and 256 zero-extended 10-bit
//               coefficients out, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polyt1_unpack_stream
    import dilithium_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEFF_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [8:0] C_NBYTES     = 9'(NBYTES);
    localparam logic [8:0] C_LAST_BYTE  = 9'(NBYTES - 1);
    localparam logic [7:0] C_LAST_COEFF = 8'(N - 1);
    localparam logic [CNT_W-1:0] C_TBITS = CNT_W'(TBITS);

    state_t            r_state;
    logic [8:0]        r_bytecnt;
    logic [7:0]        r_coeffcnt;
    logic              r_err;

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [TBITS-1:0]  w_bits;
    logic [CNT_W-1:0]  w_cnt;

    // Both handshake qualifiers depend only on registered state, so there is
    // no combinational path from the input side to the output side.
    assign w_in_ready  = (r_state == RUN) && (w_cnt < C_TBITS) && (r_bytecnt < C_NBYTES);
    assign w_out_valid = (r_state == RUN) && (w_cnt >= C_TBITS);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;
    assign w_clr       = (r_state == IDLE) && start;

    t1_bitbuf u_bitbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_push (w_push),
        .i_byte (in_data),
        .i_pop  (w_pop),
        .o_bits (w_bits),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bytecnt  <= '0;
            r_coeffcnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_bytecnt  <= '0;
                        r_coeffcnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_bytecnt <= r_bytecnt + 9'd1;
                        // in_last must coincide exactly with the final byte.
                        if (in_last != (r_bytecnt == C_LAST_BYTE)) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (w_pop) begin
                        r_coeffcnt <= r_coeffcnt + 8'd1;
                        if (r_coeffcnt == C_LAST_COEFF) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = COEFF_W'(w_bits);
    assign out_last  = w_out_valid && (r_coeffcnt == C_LAST_COEFF);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = r_err;

endmodule : polyt1_unpack_stream

`default_nettype wire

// File: tb/tb_polyt1_unpack_stream.sv
// ============================================================================
// Module      : tb_polyt1_unpack_stream
// Description : Self-checking bench for polyt1_unpack_stream: table of
//               polynomial runs plus reset-abort sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_polyt1_unpack_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    polyt1_unpack_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int   kind;        // 0: 01 04 10 40 00 pattern, 1: FF 03 then zeros, 2: random
        int   in_gap;      // percent of cycles with in_valid low
        int   out_gap;     // percent of cycles with out_ready low
        int   last_extra;  // byte index carrying a spurious in_last, -1 none
        int   hold;        // cycles of forced out_ready=0 after byte 3
        int   start_mid;   // pulse start while RUN
        int   abort_at;    // coefficient index to abort at, -1 none
        logic exp_err;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] bytes [320];
    logic [9:0] exp_c [256];
    vec_t       vecs  [7];
    logic [7:0] pat   [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic prepare(input int kind);
        pat[0] = 8'h01; pat[1] = 8'h04; pat[2] = 8'h10; pat[3] = 8'h40; pat[4] = 8'h00;
        if (kind == 0) begin
            for (int b = 0; b < 320; b++) bytes[b] = pat[b % 5];
            for (int c = 0; c < 256; c++) exp_c[c] = 10'h001;
        end else if (kind == 1) begin
            for (int b = 0; b < 320; b++) bytes[b] = 8'h00;
            bytes[0] = 8'hFF;
            bytes[1] = 8'h03;
            for (int c = 0; c < 256; c++) exp_c[c] = 10'h000;
            exp_c[0] = 10'h3FF;
        end else begin
            for (int c = 0; c < 256; c++) exp_c[c] = 10'($urandom_range(1023));
            // Reference packer: 4 coefficients per 5 bytes, LSB-first.
            for (int g = 0; g < 64; g++) begin
                logic [9:0] c0, c1, c2, c3;
                c0 = exp_c[4*g]; c1 = exp_c[4*g+1]; c2 = exp_c[4*g+2]; c3 = exp_c[4*g+3];
                bytes[5*g]   = c0[7:0];
                bytes[5*g+1] = {c1[5:0], c0[9:8]};
                bytes[5*g+2] = {c2[3:0], c1[9:6]};
                bytes[5*g+3] = {c3[1:0], c2[9:4]};
                bytes[5*g+4] = c3[9:2];
            end
        end
    endtask

    task automatic run_poly(input vec_t v);
        int   j, k, cyc, hold_left;
        logic held, err_pending, mid_done;
        logic [31:0] held_data;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_cleared_by_start", 32'(err), 32'd0);
        chk("in_ready_after_start", 32'(in_ready), 32'd1);
        chk("out_valid_after_start", 32'(out_valid), 32'd0);
        j = 0; k = 0; cyc = 0; hold_left = v.hold;
        held = 1'b0; err_pending = 1'b0; mid_done = 1'b0; held_data = '0;
        while (k < 256 && cyc < 5000) begin
            start = 1'b0;
            if (err_pending) begin
                chk("err_next_cycle", 32'(err), 32'd1);
                err_pending = 1'b0;
            end
            if (held) begin
                chk("held_valid", 32'(out_valid), 32'd1);
                chk("held_data_stable", out_data, held_data);
            end
            if (out_valid) chk("in_ready_low_when_full", 32'(in_ready), 32'd0);
            if (v.abort_at >= 0 && k == v.abort_at) break;
            out_ready = ($urandom_range(99) >= v.out_gap);
            if (v.hold > 0 && j >= 3 && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end
            if (v.start_mid != 0 && j == 50 && !mid_done) begin
                start = 1'b1;
                mid_done = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("coeff[%0d]", k), out_data, {22'b0, exp_c[k]});
                chk($sformatf("out_last[%0d]", k), 32'(out_last), 32'(k == 255));
                k++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (j < 320 && $urandom_range(99) >= v.in_gap) begin
                in_valid = 1'b1;
                in_data  = bytes[j];
                in_last  = (j == 319) || (j == v.last_extra);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                in_last  = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (j == v.last_extra) err_pending = 1'b1;
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 5000) begin
            chk("timeout", 32'(k), 32'd256);
        end else if (v.abort_at < 0) begin
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b0;
            chk("bytes_consumed", 32'(j), 32'd320);
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("out_valid_in_done", 32'(out_valid), 32'd0);
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("err_final", 32'(err), 32'(v.exp_err));
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("err_sticky", 32'(err), 32'(v.exp_err));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{0,  0,  0,  -1, 0, 0,  -1, 1'b0};
        vecs[1] = '{1, 20, 20,  -1, 0, 0,  -1, 1'b0};
        vecs[2] = '{2, 30, 30,  -1, 0, 0,  -1, 1'b0};
        vecs[3] = '{2, 10, 10, 100, 0, 0,  -1, 1'b1};
        vecs[4] = '{2,  0,  0,  -1, 8, 0,  -1, 1'b0};
        vecs[5] = '{2,  0,  0,  -1, 0, 0, 130, 1'b0};
        vecs[6] = '{2, 15, 15,  -1, 0, 1,  -1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            prepare(vecs[i].kind);
            run_poly(vecs[i]);
            if (vecs[i].abort_at >= 0) begin
                rst_n = 1'b0;
                #1;
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd0);
                chk("abort_out_data", out_data, 32'd0);
                chk("abort_out_last", 32'(out_last), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_err", 32'(err), 32'd0);
                in_valid  = 1'b0;
                in_last   = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_idle", 32'(busy), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_polyt1_unpack_stream

`default_nettype wire
